// File: rtl/tf_loader_if.sv
// Valid/ready word stream feeding the twiddle-factor loader.
// The master drives s_valid/s_data and the slave returns s_ready.
`ifndef D_width
`define D_width 16
`endif

interface tf_loader_if #(
  parameter int DW = `D_width
);
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/tf_loader.sv
// Twiddle-factor loader: per level, 15 base words then 14 constant words, then a commit strobe.
// Optional macro TF_LOAD_RANGE_CHK_EN zeroes words >= modulus and raises a sticky err.
//   state      | meaning
//   IDLE       | waiting for start
//   LOAD_BASE  | accepting base words 0..14
//   LOAD_CONST | accepting constant words 0..13
//   COMMIT     | one-cycle load_wen for the current depth
//   DONE       | one-cycle done pulse
`ifndef D_width
`define D_width 16
`endif

module tf_loader #(
  parameter int LEVELS = 3,
  parameter int DW     = `D_width
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] modulus,
  tf_loader_if.slave    s,
  output logic [DW-1:0] TF_base_out0,
  output logic [DW-1:0] TF_base_out1,
  output logic [DW-1:0] TF_base_out2,
  output logic [DW-1:0] TF_base_out3,
  output logic [DW-1:0] TF_base_out4,
  output logic [DW-1:0] TF_base_out5,
  output logic [DW-1:0] TF_base_out6,
  output logic [DW-1:0] TF_base_out7,
  output logic [DW-1:0] TF_base_out8,
  output logic [DW-1:0] TF_base_out9,
  output logic [DW-1:0] TF_base_out10,
  output logic [DW-1:0] TF_base_out11,
  output logic [DW-1:0] TF_base_out12,
  output logic [DW-1:0] TF_base_out13,
  output logic [DW-1:0] TF_base_out14,
  output logic [DW-1:0] TF_const_out0,
  output logic [DW-1:0] TF_const_out1,
  output logic [DW-1:0] TF_const_out2,
  output logic [DW-1:0] TF_const_out3,
  output logic [DW-1:0] TF_const_out4,
  output logic [DW-1:0] TF_const_out5,
  output logic [DW-1:0] TF_const_out6,
  output logic [DW-1:0] TF_const_out7,
  output logic [DW-1:0] TF_const_out8,
  output logic [DW-1:0] TF_const_out9,
  output logic [DW-1:0] TF_const_out10,
  output logic [DW-1:0] TF_const_out11,
  output logic [DW-1:0] TF_const_out12,
  output logic [DW-1:0] TF_const_out13,
  output logic          load_wen,
  output logic [DW-1:0] load_depth,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_BASE,
    LOAD_CONST,
    COMMIT,
    DONE
  } state_t;

  state_t        state;
  logic [3:0]    count;
  logic [DW-1:0] depth;
  logic          rdy_q;
  logic [DW-1:0] base_q [15];
  logic [DW-1:0] cnst_q [14];
  logic          hs;
  logic [DW-1:0] word;

  assign s.s_ready = rdy_q;
  assign hs        = s.s_valid && rdy_q;

`ifdef TF_LOAD_RANGE_CHK_EN
  logic word_bad;
  assign word_bad = (s.s_data >= modulus);
  assign word     = word_bad ? '0 : s.s_data;
`else
  logic unused_modulus;
  assign unused_modulus = ^modulus;
  assign word           = s.s_data;
  assign err            = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      depth      <= '0;
      rdy_q      <= 1'b0;
      base_q     <= '{default: '0};
      cnst_q     <= '{default: '0};
      load_wen   <= 1'b0;
      load_depth <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef TF_LOAD_RANGE_CHK_EN
      err        <= 1'b0;
`endif
    end else begin
      load_wen <= 1'b0;
      done     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD_BASE;
            count <= '0;
            depth <= '0;
            busy  <= 1'b1;
            rdy_q <= 1'b1;
`ifdef TF_LOAD_RANGE_CHK_EN
            err   <= 1'b0;
`endif
          end
        end
        LOAD_BASE: begin
          if (hs) begin
            base_q[count] <= word;
`ifdef TF_LOAD_RANGE_CHK_EN
            if (word_bad) err <= 1'b1;
`endif
            if (count == 4'd14) begin
              count <= '0;
              state <= LOAD_CONST;
            end else begin
              count <= count + 4'd1;
            end
          end
        end
        LOAD_CONST: begin
          if (hs) begin
            cnst_q[count] <= word;
`ifdef TF_LOAD_RANGE_CHK_EN
            if (word_bad) err <= 1'b1;
`endif
            if (count == 4'd13) begin
              count      <= '0;
              state      <= COMMIT;
              rdy_q      <= 1'b0;
              load_wen   <= 1'b1;
              load_depth <= depth;
            end else begin
              count <= count + 4'd1;
            end
          end
        end
        COMMIT: begin
          if (depth == DW'(LEVELS - 1)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            depth <= depth + 1'b1;
            state <= LOAD_BASE;
            rdy_q <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign TF_base_out0   = base_q[0];
  assign TF_base_out1   = base_q[1];
  assign TF_base_out2   = base_q[2];
  assign TF_base_out3   = base_q[3];
  assign TF_base_out4   = base_q[4];
  assign TF_base_out5   = base_q[5];
  assign TF_base_out6   = base_q[6];
  assign TF_base_out7   = base_q[7];
  assign TF_base_out8   = base_q[8];
  assign TF_base_out9   = base_q[9];
  assign TF_base_out10  = base_q[10];
  assign TF_base_out11  = base_q[11];
  assign TF_base_out12  = base_q[12];
  assign TF_base_out13  = base_q[13];
  assign TF_base_out14  = base_q[14];
  assign TF_const_out0  = cnst_q[0];
  assign TF_const_out1  = cnst_q[1];
  assign TF_const_out2  = cnst_q[2];
  assign TF_const_out3  = cnst_q[3];
  assign TF_const_out4  = cnst_q[4];
  assign TF_const_out5  = cnst_q[5];
  assign TF_const_out6  = cnst_q[6];
  assign TF_const_out7  = cnst_q[7];
  assign TF_const_out8  = cnst_q[8];
  assign TF_const_out9  = cnst_q[9];
  assign TF_const_out10 = cnst_q[10];
  assign TF_const_out11 = cnst_q[11];
  assign TF_const_out12 = cnst_q[12];
  assign TF_const_out13 = cnst_q[13];

endmodule

// File: doc/tf_loader.md
TF_LOADER -- requirements
Module: tf_loader

Interface
REQ-001 Parameter LEVELS, default 3: number of iteration-depth levels loaded per start.
REQ-002 Parameter DW, default `D_width: data word width, taken from the shared define header.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 start  in  1  single-cycle load request.
REQ-006 modulus  in  DW  NTT modulus; used only when range checking is compiled in.
REQ-007 s_valid  in  1  input word valid.
REQ-008 s_ready  out  1  loader accepts a word this cycle.
REQ-009 s_data  in  DW  input twiddle word.
REQ-010 TF_base_out0..TF_base_out14  out  DW each  registered base twiddle bank values.
REQ-011 TF_const_out0..TF_const_out13  out  DW each  registered constant-multiplier bank values.
REQ-012 load_wen  out  1  one-cycle commit strobe for the current level.
REQ-013 load_depth  out  DW  level index qualified by load_wen.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle pulse after the last level commits.
REQ-016 err  out  1  sticky out-of-range flag.

Function
REQ-017 FSM states SHALL be IDLE, LOAD_BASE, LOAD_CONST, COMMIT and DONE.
REQ-018 A handshake SHALL occur on a rising edge with s_valid=1 and s_ready=1; s_ready SHALL be 1 only in LOAD_BASE and LOAD_CONST.
REQ-019 IDLE with start=1 -> LOAD_BASE, with word count=0 and depth=0; start SHALL be ignored in every other state.
REQ-020 LOAD_BASE: each handshake writes s_data into TF_base_out[count] and increments count; the handshake at count=14 -> LOAD_CONST with count=0.
REQ-021 LOAD_CONST: each handshake writes TF_const_out[count]; the handshake at count=13 -> COMMIT.
REQ-022 Each level consumes exactly 29 words: 15 base words, then 14 const words.
REQ-023 COMMIT lasts one cycle with load_wen=1 and load_depth=depth.
REQ-024 From COMMIT: if depth=LEVELS-1 -> DONE; otherwise depth increments and -> LOAD_BASE with count=0.
REQ-025 DONE lasts one cycle with done=1, then -> IDLE.
REQ-026 Bank outputs SHALL change only on handshakes and SHALL hold their values through COMMIT, DONE and IDLE.
REQ-027 s_valid=0 while loading stalls the loader, with state, count and outputs unchanged.
REQ-028 Latency: load_wen SHALL assert one cycle after the 29th handshake of a level.
REQ-029 Outside COMMIT, load_wen=0 and load_depth holds its last value.

Reset
REQ-030 rst=1 SHALL force IDLE, count=0, depth=0, all bank outputs=0, load_depth=0, and load_wen, done, err, busy, s_ready all 0.
REQ-031 rst asserted mid-load SHALL abort the load immediately; no load_wen or done pulse occurs.

Configuration
REQ-032 Macro TF_LOAD_RANGE_CHK_EN: when defined, an accepted word >= modulus SHALL be stored as 0 and SHALL set err, which stays set until rst or the next accepted start.
REQ-033 When TF_LOAD_RANGE_CHK_EN is undefined, words SHALL be stored verbatim, err SHALL be tied to 0, and modulus is unused.

Verification
REQ-034 Reset then start, 29 words 1..29 with s_valid held high -> TF_base_out0=1, TF_base_out14=15, TF_const_out0=16, TF_const_out13=29; load_wen on cycle 30 with load_depth=0.
REQ-035 LEVELS=3, 87 words back-to-back -> load_wen pulses with depth 0, 1, 2; done exactly one cycle after the third commit; busy falls with done.
REQ-036 s_valid toggled every other cycle -> identical bank contents to REQ-034; load_wen delayed by the stall count.
REQ-037 start pulsed while busy -> no restart; depth and count sequence unaffected.
REQ-038 rst pulsed after word 10 -> all outputs 0 and state IDLE; a new start reloads correctly.
REQ-039 With TF_LOAD_RANGE_CHK_EN, modulus=17, word 20 at base slot 3 -> TF_base_out3=0 and err=1; without the macro -> TF_base_out3=20 and err=0.
